uart_rx_fifo: RTL

- Receive-side byte buffer between the uart block's rxnew/rxdata strobe outputs and the CPU bus.
- Without it, a received byte is lost if software does not read it before the next byte arrives; at 921600 baud that is about 10.8 us.
- The block queues up to 2^DEPTH_LOG2 bytes, counts overflows, and raises a level interrupt once a programmable fill threshold is reached.
- It attaches to mmapper like any other word-indexed peripheral and its irq feeds interrupt_unit.

---
 rtl/uart_rx_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the uart rxnew/rxdata strobe and the CPU bus.
// Queues bytes, counts overflows and raises a registered threshold interrupt.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int THRESH_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxnew,
    input  logic [7:0]  rxdata,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [8:0]            thresh;
    logic                  ovf_flag;
    logic [15:0]           ovf_cnt;

    logic empty, full, ctrl_wr, flush, pop_ok, push_ok, ovf, ovf_clr, cnt_clr, thresh_wr;
    logic [7:0] count_byte;
    logic unused_bits;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign ctrl_wr   = we && (a == 3'd1);
    assign flush     = ctrl_wr && d[2];
    assign ovf_clr   = ctrl_wr && d[1];
    assign thresh_wr = we && (a == 3'd2);
    assign cnt_clr   = we && (a == 3'd3);
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign pop_ok    = rst && ctrl_wr && d[0] && !flush && !empty;
    assign push_ok   = rst && rxnew && !flush && (!full || pop_ok);
    assign ovf       = rst && rxnew && !flush && full && !pop_ok;
    assign count_byte  = 8'(count);
    assign unused_bits = ^d[31:9];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
            thresh   <= 9'(THRESH_RESET);
            irq      <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                if (push_ok && !pop_ok)      count <= count + CW'(1);
                else if (pop_ok && !push_ok) count <= count - CW'(1);
            end

            if (ovf)          ovf_flag <= 1'b1;
            else if (ovf_clr) ovf_flag <= 1'b0;

            if (cnt_clr)                         ovf_cnt <= '0;
            else if (ovf && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;

            if (thresh_wr) thresh <= d[8:0];

            // Registered from the already-updated count, hence two cycles after a push.
            irq <= (thresh != 9'd0) && (9'(count) >= thresh);
        end
    end

    // NOTE: the byte array has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rxdata;
    end

    always_comb begin
        spo = '0;
        case (a)
            3'd0: if (!empty) spo = {24'b0, mem[rd_ptr]};
            3'd1: spo = {16'b0, count_byte, 5'b0, ovf_flag, full, empty};
            3'd2: spo = {23'b0, thresh};
            3'd3: spo = {16'b0, ovf_cnt};
            default: spo = '0;
        endcase
    end

endmodule
